stopwatch_dp: RTL and testbench

//   Stopwatch datapath driven by the stopwatch control FSM's o_run/o_clear outputs.

---
 rtl/stopwatch_defs.sv | 21 ++
 rtl/time_counter.sv | 33 +++
 rtl/stopwatch_dp.sv | 80 ++++++++
 tb/tb_stopwatch_dp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_defs.sv
// rtl/stopwatch_defs.sv - shared moduli, output widths and control encoding for the stopwatch
package stopwatch_defs;

  localparam int MSEC_MAX_DEF = 100;
  localparam int SEC_MAX_DEF  = 60;
  localparam int MIN_MAX_DEF  = 60;
  localparam int HOUR_MAX_DEF = 24;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // Mode encoding shared with the control FSM that drives i_run/i_clear.
  typedef enum logic [1:0] {
    SW_STOP  = 2'd0,
    SW_RUN   = 2'd1,
    SW_CLEAR = 2'd2
  } sw_mode_e;

endpackage

// File: rtl/time_counter.sv
// rtl/time_counter.sv - one modulo-MAX digit of the stopwatch cascade with combinational carry out
module time_counter #(
  parameter int MAX = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt,
  output logic         o_carry
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == W'(MAX - 1));
  // Carry is combinational so the next digit advances in the same edge.
  assign o_carry  = i_tick && w_at_max;
  assign o_cnt    = r_cnt;

  // Count register: clear wins, otherwise advance and wrap on carry-in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_dp.sv
// rtl/stopwatch_dp.sv - stopwatch datapath: 1/100 s prescaler and cascaded msec/sec/min/hour counters
module stopwatch_dp
  import stopwatch_defs::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int MSEC_MAX    = MSEC_MAX_DEF,
  parameter int SEC_MAX     = SEC_MAX_DEF,
  parameter int MIN_MAX     = MIN_MAX_DEF,
  parameter int HOUR_MAX    = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_clear,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_presc_last;
  logic          w_msec_carry;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic          w_hour_carry_unused;

  assign w_presc_last = (r_presc == PW'(DIV - 1));
  assign o_tick       = r_tick;

  // Prescaler holds its partial count while paused so no fraction is lost on resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (i_run) begin
      r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
      r_tick  <= w_presc_last;
    end else begin
      r_tick  <= 1'b0;
    end
  end

  // Moduli larger than the fixed output widths cannot be represented.
  always_ff @(posedge clk) begin
    assert (DIV >= 2 && MSEC_MAX <= (1 << MSEC_W) && SEC_MAX <= (1 << SEC_W) &&
            MIN_MAX <= (1 << MIN_W) && HOUR_MAX <= (1 << HOUR_W))
      else $error("stopwatch_dp: bad DIV or modulus exceeds output width");
  end

  time_counter #(.MAX(MSEC_MAX), .W(MSEC_W)) u_msec (
    .clk(clk), .rst(rst), .i_tick(r_tick), .i_clear(i_clear),
    .o_cnt(o_msec), .o_carry(w_msec_carry)
  );

  time_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .i_tick(w_msec_carry), .i_clear(i_clear),
    .o_cnt(o_sec), .o_carry(w_sec_carry)
  );

  time_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .i_tick(w_sec_carry), .i_clear(i_clear),
    .o_cnt(o_min), .o_carry(w_min_carry)
  );

  time_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(clk), .rst(rst), .i_tick(w_min_carry), .i_clear(i_clear),
    .o_cnt(o_hour), .o_carry(w_hour_carry_unused)
  );

endmodule

// File: tb/tb_stopwatch_dp.sv
// tb/tb_stopwatch_dp.sv - randomized and directed self-checking bench for stopwatch_dp
module tb_stopwatch_dp;

  localparam int DIV = 10;
  localparam int M1 = 100, S1 = 60, N1 = 60, H1 = 24;
  localparam int M2 = 4,   S2 = 3,  N2 = 3,  H2 = 2;
  localparam int DAY1 = M1 * S1 * N1 * H1;
  localparam int DAY2 = M2 * S2 * N2 * H2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_run = 1'b1;
  logic       i_clear = 1'b0;
  logic [6:0] o_msec, s_msec;
  logic [5:0] o_sec, s_sec;
  logic [5:0] o_min, s_min;
  logic [4:0] o_hour, s_hour;
  logic       o_tick, s_tick;

  int tests = 0;
  int fails = 0;

  int run_clks = 0;
  int t_main = 0;
  int t_small = 0;
  bit tick_m = 1'b0;

  always #5 clk = ~clk;

  stopwatch_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) u_dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick)
  );

  stopwatch_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100),
                 .MSEC_MAX(M2), .SEC_MAX(S2), .MIN_MAX(N2), .HOUR_MAX(H2)) u_dut_small (
    .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear),
    .o_msec(s_msec), .o_sec(s_sec), .o_min(s_min), .o_hour(s_hour), .o_tick(s_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a tick every DIV enabled clocks since clear; time is a single
  // centisecond total split into fields by division.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_clks <= 0;
      tick_m   <= 1'b0;
      t_main   <= 0;
      t_small  <= 0;
    end else if (i_clear) begin
      run_clks <= 0;
      tick_m   <= 1'b0;
      t_main   <= 0;
      t_small  <= 0;
    end else begin
      if (i_run) run_clks <= run_clks + 1;
      tick_m <= i_run && ((run_clks + 1) % DIV == 0);
      if (tick_m) begin
        t_main  <= (t_main + 1) % DAY1;
        t_small <= (t_small + 1) % DAY2;
      end
    end
  end

  always @(negedge clk) begin
    chk("tick", o_tick, tick_m);
    chk("msec", o_msec, t_main % M1);
    chk("sec", o_sec, (t_main / M1) % S1);
    chk("min", o_min, (t_main / (M1 * S1)) % N1);
    chk("hour", o_hour, t_main / (M1 * S1 * N1));
    chk("s_tick", s_tick, tick_m);
    chk("s_msec", s_msec, t_small % M2);
    chk("s_sec", s_sec, (t_small / M2) % S2);
    chk("s_min", s_min, (t_small / (M2 * S2)) % N2);
    chk("s_hour", s_hour, t_small / (M2 * S2 * N2));
  end

  task automatic count_to_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tick && n < limit);
  endtask

  task automatic do_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  initial begin
    int n, ticks, last, cyc;
    bit found;

    // Reset held with run asserted: everything stays zero.
    repeat (3) @(negedge clk);
    chk("rst_msec", o_msec, 0);
    chk("rst_sec", o_sec, 0);
    chk("rst_tick", o_tick, 0);
    rst = 1'b1;
    count_to_tick(50, n);
    chk("first_tick_clks", n, 10);
    @(negedge clk);
    chk("first_msec", o_msec, 1);

    // 1000 run clocks from clear: 100 evenly spaced ticks, then 00:00:01.00.
    do_clear();
    ticks = 0;
    last = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (o_tick) begin
        ticks++;
        if (last >= 0) chk("tick_spacing", i - last, 10);
        last = i;
      end
    end
    i_run = 1'b0;
    @(negedge clk);
    chk("run1000_ticks", ticks, 100);
    chk("run1000_msec", o_msec, 0);
    chk("run1000_sec", o_sec, 1);

    // Pause mid-period keeps the partial count.
    i_run = 1'b1;
    do_clear();
    repeat (15) @(negedge clk);
    i_run = 1'b0;
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_tick) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    chk("pause_msec", o_msec, 1);
    i_run = 1'b1;
    count_to_tick(50, n);
    chk("resume_tick_clks", n, 5);

    // Clear beats run at 00:00:03.42 and restarts the prescaler.
    do_clear();
    found = 1'b0;
    for (cyc = 0; cyc < 5000 && !found; cyc++) begin
      @(negedge clk);
      found = (o_sec == 3 && o_msec == 42);
    end
    chk("reach_3_42", found, 1);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    chk("clr_msec", o_msec, 0);
    chk("clr_sec", o_sec, 0);
    chk("clr_tick", o_tick, 0);
    count_to_tick(50, n);
    chk("clr_restart_clks", n, 10);

    // Full rollover on the shortened-moduli instance.
    do_clear();
    found = 1'b0;
    for (cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(negedge clk);
      found = (s_msec == 3 && s_sec == 2 && s_min == 2 && s_hour == 1);
    end
    chk("reach_max", found, 1);
    found = 1'b0;
    for (cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      found = (s_msec != 3);
    end
    chk("roll_seen", found, 1);
    chk("roll_msec", s_msec, 0);
    chk("roll_sec", s_sec, 0);
    chk("roll_min", s_min, 0);
    chk("roll_hour", s_hour, 0);

    // Randomized run/pause/clear traffic checked cycle by cycle.
    repeat (3000) begin
      @(negedge clk);
      i_run   = ($urandom % 4) != 0;
      i_clear = ($urandom % 64) == 0;
    end
    i_clear = 1'b0;
    i_run   = 1'b1;

    // Async reset mid-count at 00:01:07.55.
    do_clear();
    found = 1'b0;
    for (cyc = 0; cyc < 70000 && !found; cyc++) begin
      @(negedge clk);
      found = (o_hour == 0 && o_min == 1 && o_sec == 7 && o_msec == 55);
    end
    chk("reach_1_07_55", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_msec", o_msec, 0);
    chk("arst_sec", o_sec, 0);
    chk("arst_min", o_min, 0);
    chk("arst_hour", o_hour, 0);
    chk("arst_tick", o_tick, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
